// File: rtl/sa_cache.sv
// -----------------------------------------------------------------------------
// sa_cache: 4-way set-associative, write-allocate cache with 2**INDEX_W sets
// and one DATA_W word per line. Hits complete in one cycle. A miss stalls in
// REFILL until the memory strobe arrives. Replacement is true LRU, kept as
// per-way ages 0..3.
//
// Build option: SA_CACHE_WRITE_THROUGH_EN
//   undefined : write-back. A dirty victim is emitted on the evict port.
//   defined   : write-through. Every store, hit or miss, emits
//               {i_tag,i_index,0}/dataW on the evict port. No line ever
//               becomes dirty.
//
// Ports
//   clk               clock, rising edge
//   rst               asynchronous active-low reset
//   i_tag/i_index     request address fields (i_offset is ignored)
//   dataW, memRW      store data; 0=load, 1=store
//   i_memory_line     refill word; valid while i_memory_response=1
//   o_data            load/store result (registered)
//   line_data         last word delivered by memory (registered)
//   cache_miss        high while a miss is outstanding
//   o_evict*          one-cycle write-back strobe with its address and data
// -----------------------------------------------------------------------------
module sa_cache #(
    parameter int unsigned TAG_W    = 18,
    parameter int unsigned INDEX_W  = 8,
    parameter int unsigned OFFSET_W = 6,
    parameter int unsigned DATA_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [TAG_W-1:0]    i_tag,
    input  logic [INDEX_W-1:0]  i_index,
    input  logic [OFFSET_W-1:0] i_offset,
    input  logic [DATA_W-1:0]   dataW,
    input  logic                memRW,
    input  logic [DATA_W-1:0]   i_memory_line,
    input  logic                i_memory_response,
    output logic [DATA_W-1:0]   o_data,
    output logic [DATA_W-1:0]   line_data,
    output logic                cache_miss,
    output logic [DATA_W-1:0]   o_evict_data,
    output logic [31:0]         o_evict_addr,
    output logic                o_evict
);

    localparam int unsigned SETS = 1 << INDEX_W;
    localparam int unsigned WAYS = 4;

    typedef enum logic {LOOKUP, REFILL} state_t;

    state_t r_state, w_next_state;

    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];
    logic [1:0]        r_age   [SETS][WAYS];
    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAYS-1:0]   r_dirty [SETS];
    logic [1:0]        r_victim;

    logic       w_hit;
    logic [1:0] w_hit_way;
    logic       w_inv_found;
    logic [1:0] w_inv_way;
    logic [1:0] w_lru_way;
    logic [1:0] w_victim;
    logic       w_lookup_hit;
    logic       w_miss_start;
    logic       w_refill_done;
    logic       w_touch_en;
    logic [1:0] w_touch_way;
    logic       w_unused_offset;

    assign w_unused_offset = ^i_offset;

    // Tag compare and victim selection for the addressed set.
    always_comb begin
        w_hit       = 1'b0;
        w_hit_way   = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        w_lru_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (r_valid[i_index][w] && (r_tag[i_index][w] == i_tag) && !w_hit) begin
                w_hit     = 1'b1;
                w_hit_way = w[1:0];
            end
            if (!r_valid[i_index][w] && !w_inv_found) begin
                w_inv_found = 1'b1;
                w_inv_way   = w[1:0];
            end
            if (r_age[i_index][w] == 2'd3) begin
                w_lru_way = w[1:0];
            end
        end
        w_victim = w_inv_found ? w_inv_way : w_lru_way;
    end

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= LOOKUP;
        else      r_state <= w_next_state;
    end

    // FSM: next state
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LOOKUP:  if (!w_hit)            w_next_state = REFILL;
            REFILL:  if (i_memory_response) w_next_state = LOOKUP;
            default:                        w_next_state = LOOKUP;
        endcase
    end

    // FSM: control decode
    always_comb begin
        w_lookup_hit  = (r_state == LOOKUP) && w_hit;
        w_miss_start  = (r_state == LOOKUP) && !w_hit;
        w_refill_done = (r_state == REFILL) && i_memory_response;
        w_touch_en    = w_lookup_hit || w_refill_done;
        w_touch_way   = (r_state == REFILL) ? r_victim : w_hit_way;
    end

    // Tag and data arrays need no reset because valid gates every use.
    always_ff @(posedge clk) begin
        if (w_refill_done) begin
            r_tag[i_index][w_touch_way]  <= i_tag;
            r_data[i_index][w_touch_way] <= memRW ? dataW : i_memory_line;
        end else if (w_lookup_hit && memRW) begin
            r_data[i_index][w_touch_way] <= dataW;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    r_age[s][w] <= w[1:0];
                end
            end
            r_victim     <= '0;
            o_data       <= '0;
            line_data    <= '0;
            cache_miss   <= 1'b0;
            o_evict      <= 1'b0;
            o_evict_data <= '0;
            o_evict_addr <= '0;
        end else begin
            o_evict <= 1'b0;

            // LRU: touched way becomes age 0 and ways younger than it age by one.
            if (w_touch_en) begin
                for (int unsigned w = 0; w < WAYS; w++) begin
                    if (w[1:0] == w_touch_way)
                        r_age[i_index][w] <= 2'd0;
                    else if (r_age[i_index][w] < r_age[i_index][w_touch_way])
                        r_age[i_index][w] <= r_age[i_index][w] + 2'd1;
                end
            end

            if (w_lookup_hit) begin
                if (memRW) begin
                    o_data <= dataW;
`ifndef SA_CACHE_WRITE_THROUGH_EN
                    r_dirty[i_index][w_hit_way] <= 1'b1;
`endif
                end else begin
                    o_data <= r_data[i_index][w_hit_way];
                end
            end

            if (w_miss_start) begin
                r_victim   <= w_victim;
                cache_miss <= 1'b1;
`ifndef SA_CACHE_WRITE_THROUGH_EN
                if (r_valid[i_index][w_victim] && r_dirty[i_index][w_victim]) begin
                    o_evict      <= 1'b1;
                    o_evict_data <= r_data[i_index][w_victim];
                    o_evict_addr <= {r_tag[i_index][w_victim], i_index, {OFFSET_W{1'b0}}};
                end
`endif
            end

            if (w_refill_done) begin
                r_valid[i_index][r_victim] <= 1'b1;
`ifdef SA_CACHE_WRITE_THROUGH_EN
                r_dirty[i_index][r_victim] <= 1'b0;
`else
                r_dirty[i_index][r_victim] <= memRW;
`endif
                line_data  <= i_memory_line;
                o_data     <= memRW ? dataW : i_memory_line;
                cache_miss <= 1'b0;
            end

`ifdef SA_CACHE_WRITE_THROUGH_EN
            if ((w_lookup_hit || w_refill_done) && memRW) begin
                o_evict      <= 1'b1;
                o_evict_data <= dataW;
                o_evict_addr <= {i_tag, i_index, {OFFSET_W{1'b0}}};
            end
`endif
        end
    end

endmodule

// File: tb/tb_sa_cache.sv
module tb_sa_cache;

`ifdef SA_CACHE_WRITE_THROUGH_EN
    localparam bit WT = 1'b1;
`else
    localparam bit WT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] i_tag = '0;
    logic [7:0]  i_index = '0;
    logic [5:0]  i_offset = '0;
    logic [31:0] dataW = '0;
    logic        memRW = 1'b0;
    logic [31:0] i_memory_line = '0;
    logic        i_memory_response = 1'b0;
    logic [31:0] o_data, line_data, o_evict_data, o_evict_addr;
    logic        cache_miss, o_evict;

    int n_cmp = 0;
    int n_err = 0;

    sa_cache dut (
        .clk(clk), .rst(rst), .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset),
        .dataW(dataW), .memRW(memRW), .i_memory_line(i_memory_line),
        .i_memory_response(i_memory_response), .o_data(o_data), .line_data(line_data),
        .cache_miss(cache_miss), .o_evict_data(o_evict_data), .o_evict_addr(o_evict_addr),
        .o_evict(o_evict)
    );

    always #5 clk = ~clk;

    // Reference model: per-set contents plus a recency list (position 0 = MRU).
    bit          m_valid [256][4];
    bit          m_dirty [256][4];
    logic [17:0] m_tag   [256][4];
    logic [31:0] m_data  [256][4];
    int          m_ord   [256][4];
    logic [31:0] m_last_line;

    task automatic model_reset();
        for (int s = 0; s < 256; s++)
            for (int w = 0; w < 4; w++) begin
                m_valid[s][w] = 1'b0;
                m_dirty[s][w] = 1'b0;
                m_ord[s][w]   = w;
            end
        m_last_line = '0;
    endtask

    task automatic model_touch(input int s, input int way);
        int p;
        p = 0;
        for (int k = 0; k < 4; k++) if (m_ord[s][k] == way) p = k;
        for (int k = p; k > 0; k--) m_ord[s][k] = m_ord[s][k-1];
        m_ord[s][0] = way;
    endtask

    // One full request: a hit, or a miss with refill after `delay` stall cycles and the re-lookup.
    task automatic access(input logic [17:0] tag, input logic [7:0] idx, input bit wr,
                          input logic [31:0] wd, input logic [31:0] line, input int delay);
        int h, v;
        bit exp_ev;
        logic [31:0] exp_addr, exp_word;
        i_tag = tag; i_index = idx; memRW = wr; dataW = wd;
        i_offset = 6'($urandom); i_memory_response = 1'b0;
        h = -1;
        for (int w = 0; w < 4; w++) if (m_valid[idx][w] && m_tag[idx][w] == tag) h = w;
        @(posedge clk); #1;
        if (h >= 0) begin
            if (wr) begin
                m_data[idx][h] = wd;
                if (!WT) m_dirty[idx][h] = 1'b1;
            end
            model_touch(idx, h);
            n_cmp++;
            if (cache_miss !== 1'b0) begin n_err++; $display("FAIL hit_miss: got %b want 0", cache_miss); end
            n_cmp++;
            if (o_data !== m_data[idx][h]) begin n_err++; $display("FAIL hit_data: got %h want %h", o_data, m_data[idx][h]); end
            exp_ev = WT && wr;
            n_cmp++;
            if (o_evict !== exp_ev) begin n_err++; $display("FAIL hit_evict: got %b want %b", o_evict, exp_ev); end
            if (exp_ev) begin
                n_cmp++;
                if (o_evict_addr !== {tag, idx, 6'b0} || o_evict_data !== wd) begin
                    n_err++; $display("FAIL wt_hit_fields: got %h/%h want %h/%h", o_evict_addr, o_evict_data, {tag, idx, 6'b0}, wd);
                end
            end
        end else begin
            v = m_ord[idx][3];
            for (int w = 3; w >= 0; w--) if (!m_valid[idx][w]) v = w;
            n_cmp++;
            if (cache_miss !== 1'b1) begin n_err++; $display("FAIL miss_flag: got %b want 1", cache_miss); end
            exp_ev = !WT && m_valid[idx][v] && m_dirty[idx][v];
            n_cmp++;
            if (o_evict !== exp_ev) begin n_err++; $display("FAIL miss_evict: got %b want %b", o_evict, exp_ev); end
            if (exp_ev) begin
                exp_addr = {m_tag[idx][v], idx, 6'b0};
                n_cmp++;
                if (o_evict_addr !== exp_addr || o_evict_data !== m_data[idx][v]) begin
                    n_err++; $display("FAIL evict_fields: got %h/%h want %h/%h", o_evict_addr, o_evict_data, exp_addr, m_data[idx][v]);
                end
            end
            for (int c = 0; c < delay; c++) begin
                i_memory_line = $urandom;
                @(posedge clk); #1;
                n_cmp++;
                if (cache_miss !== 1'b1 || o_evict !== 1'b0) begin
                    n_err++; $display("FAIL stall: got miss=%b evict=%b want 1/0", cache_miss, o_evict);
                end
            end
            i_memory_line = line; i_memory_response = 1'b1;
            @(posedge clk); #1;
            i_memory_response = 1'b0;
            exp_word = wr ? wd : line;
            m_valid[idx][v] = 1'b1;
            m_dirty[idx][v] = wr && !WT;
            m_tag[idx][v]   = tag;
            m_data[idx][v]  = exp_word;
            m_last_line     = line;
            model_touch(idx, v);
            n_cmp++;
            if (cache_miss !== 1'b0) begin n_err++; $display("FAIL refill_miss: got %b want 0", cache_miss); end
            n_cmp++;
            if (line_data !== line) begin n_err++; $display("FAIL refill_line: got %h want %h", line_data, line); end
            n_cmp++;
            if (o_data !== exp_word) begin n_err++; $display("FAIL refill_data: got %h want %h", o_data, exp_word); end
            n_cmp++;
            if (o_evict !== (WT && wr)) begin n_err++; $display("FAIL refill_evict: got %b want %b", o_evict, WT && wr); end
            @(posedge clk); #1;
            n_cmp++;
            if (cache_miss !== 1'b0 || o_data !== exp_word) begin
                n_err++; $display("FAIL relookup: got miss=%b data=%h want 0/%h", cache_miss, o_data, exp_word);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({o_data, line_data, o_evict_data, o_evict_addr, cache_miss, o_evict} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h %h %h %h %b %b want all 0",
                              o_data, line_data, o_evict_data, o_evict_addr, cache_miss, o_evict);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        access(18'h1, 8'h05, 1'b0, 32'h0, 32'hDEADBEEF, 2);
        access(18'h1, 8'h05, 1'b0, 32'h0, 32'h0, 0);
        access(18'h1, 8'h05, 1'b1, 32'h12345678, 32'h0, 0);
        access(18'h1, 8'h05, 1'b0, 32'h0, 32'h0, 0);
        access(18'h2, 8'h05, 1'b0, 32'h0, 32'hA0000002, 1);
        access(18'h3, 8'h05, 1'b0, 32'h0, 32'hA0000003, 0);
        access(18'h4, 8'h05, 1'b0, 32'h0, 32'hA0000004, 3);
        // Dirty tag 0x1 is LRU: write-back of 0x12345678 to 0x00004140 expected.
        access(18'h5, 8'h05, 1'b0, 32'h0, 32'hA0000005, 1);
        access(18'h2, 8'h05, 1'b0, 32'h0, 32'h0, 0);
        // Victim is clean tag 0x3: no evict.
        access(18'h6, 8'h05, 1'b0, 32'h0, 32'hA0000006, 0);
        access(18'h3FFFF, 8'hFF, 1'b1, 32'hCAFEF00D, 32'h11111111, 0);
    endtask

    task automatic test_resp_ignored();
        access(18'h7, 8'h09, 1'b0, 32'h0, 32'h77777777, 0);
        i_tag = 18'h7; i_index = 8'h09; memRW = 1'b0;
        i_memory_line = 32'hBAD0BAD0; i_memory_response = 1'b1;
        @(posedge clk); #1;
        i_memory_response = 1'b0;
        n_cmp++;
        if (cache_miss !== 1'b0 || o_data !== 32'h77777777 || line_data !== m_last_line) begin
            n_err++; $display("FAIL resp_in_lookup: got miss=%b data=%h line=%h want 0/77777777/%h",
                              cache_miss, o_data, line_data, m_last_line);
        end
    endtask

    task automatic test_random();
        logic [7:0] idx;
        for (int n = 0; n < 400; n++) begin
            idx = ($urandom_range(0, 9) == 0) ? 8'hFF : 8'($urandom_range(0, 3));
            access(18'($urandom_range(0, 7)), idx, 1'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid_refill();
        access(18'h1, 8'h05, 1'b0, 32'h0, 32'h0BADCAFE, 0);
        i_tag = 18'h2A; i_index = 8'h05; memRW = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (cache_miss !== 1'b1) begin n_err++; $display("FAIL pre_abort_miss: got %b want 1", cache_miss); end
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if (cache_miss !== 1'b0 || o_data !== 32'h0) begin
            n_err++; $display("FAIL async_abort: got miss=%b data=%h want 0/0", cache_miss, o_data);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        // Tag 0x1 hit before the reset; it must miss now.
        access(18'h1, 8'h05, 1'b0, 32'h0, 32'h13579BDF, 1);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_resp_ignored();
        test_random();
        test_reset_mid_refill();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
